// File: rtl/uart_rx.sv
// uart_rx: oversampling serial receiver.
// Recovers start / WIDTH data bits (LSB first) / optional parity / stop frames
// from a line that idles high. Each bit is sampled three times around its
// centre and decided by majority. A good word is presented on P_DATA with a
// one-cycle DATA_VALID pulse; a bad frame gives a PAR_ERR or STP_ERR pulse instead.
//
// Handshake: there is no back-pressure. DATA_VALID, PAR_ERR and STP_ERR are
// single-cycle pulses and at most one of them is high in any cycle. P_DATA only
// changes in the cycle DATA_VALID goes high, and it holds until the next good frame.
module uart_rx #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             RX_IN,
  input  logic             PAR_EN,
  input  logic             PAR_TYP,
  output logic [WIDTH-1:0] P_DATA,
  output logic             DATA_VALID,
  output logic             PAR_ERR,
  output logic             STP_ERR,
  output logic             Busy,
  output logic [2:0]       o_dbg_state
);

  localparam int M     = PRESCALE / 2;
  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [1:0]         r_sync;
  logic [CNT_W-1:0]   r_edge_cnt;
  logic [BIT_W-1:0]   r_bit_cnt;
  logic               r_samp0;
  logic               r_samp1;
  logic [WIDTH-1:0]   r_shift;
  logic               r_par_en;
  logic               r_par_typ;
  logic               r_par_pend;
  logic [WIDTH-1:0]   r_p_data;
  logic               r_data_valid;
  logic               r_par_err;
  logic               r_stp_err;

  logic               w_rx_s;
  logic               w_samp_a;
  logic               w_samp_b;
  logic               w_decide;
  logic               w_bit_end;
  logic               w_last_bit;
  logic               w_maj;
  logic               w_exp_par;
  logic               w_valid_nxt;
  logic               w_par_err_nxt;
  logic               w_stp_err_nxt;

  assign w_rx_s     = r_sync[1];
  assign w_samp_a   = (r_edge_cnt == CNT_W'(M - 1));
  assign w_samp_b   = (r_edge_cnt == CNT_W'(M));
  assign w_decide   = (r_edge_cnt == CNT_W'(M + 1));
  assign w_bit_end  = (r_edge_cnt == CNT_W'(PRESCALE - 1));
  assign w_last_bit = (r_bit_cnt == BIT_W'(WIDTH - 1));

  // Majority of the two stored samples and the live third sample.
  assign w_maj = (r_samp0 & r_samp1) | (r_samp0 & w_rx_s) | (r_samp1 & w_rx_s);

  // Parity bit the sender should have produced for the shifted-in word.
  assign w_exp_par = (^r_shift) ^ r_par_typ;

  assign P_DATA      = r_p_data;
  assign DATA_VALID  = r_data_valid;
  assign PAR_ERR     = r_par_err;
  assign STP_ERR     = r_stp_err;
  assign Busy        = (r_state != ST_IDLE);
  assign o_dbg_state = r_state;

  // Two-flop synchroniser for the asynchronous serial line; idles high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], RX_IN};
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and frame-result decode.
  always_comb begin
    w_state_nxt   = r_state;
    w_valid_nxt   = 1'b0;
    w_par_err_nxt = 1'b0;
    w_stp_err_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_rx_s) begin
          w_state_nxt = ST_START;
        end
      end
      ST_START: begin
        // A start bit that decides high was a glitch: drop it at once.
        if (w_decide && w_maj) begin
          w_state_nxt = ST_IDLE;
        end else if (w_bit_end) begin
          w_state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_bit_end && w_last_bit) begin
          w_state_nxt = r_par_en ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (w_bit_end) begin
          w_state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        // Leave on the decision so a following start bit is not missed.
        if (w_decide) begin
          w_state_nxt = ST_IDLE;
          if (!w_maj) begin
            w_stp_err_nxt = 1'b1;
          end else if (r_par_pend) begin
            w_par_err_nxt = 1'b1;
          end else begin
            w_valid_nxt = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Per-bit edge counter and data bit counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
    end else begin
      if (r_state == ST_IDLE || w_state_nxt == ST_IDLE || w_bit_end) begin
        r_edge_cnt <= '0;
      end else begin
        r_edge_cnt <= r_edge_cnt + CNT_W'(1);
      end
      if (r_state != ST_DATA) begin
        r_bit_cnt <= '0;
      end else if (w_bit_end) begin
        r_bit_cnt <= w_last_bit ? '0 : r_bit_cnt + BIT_W'(1);
      end
    end
  end

  // First two majority samples of the current bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_samp0 <= 1'b1;
      r_samp1 <= 1'b1;
    end else begin
      if (w_samp_a) begin
        r_samp0 <= w_rx_s;
      end
      if (w_samp_b) begin
        r_samp1 <= w_rx_s;
      end
    end
  end

  // Frame options latched at start detection, data shift and parity check.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_par_en   <= 1'b0;
      r_par_typ  <= 1'b0;
      r_par_pend <= 1'b0;
      r_shift    <= '0;
    end else begin
      if (r_state == ST_IDLE && !w_rx_s) begin
        r_par_en   <= PAR_EN;
        r_par_typ  <= PAR_TYP;
        r_par_pend <= 1'b0;
      end
      if (r_state == ST_DATA && w_decide) begin
        r_shift <= {w_maj, r_shift[WIDTH-1:1]};
      end
      if (r_state == ST_PARITY && w_decide) begin
        r_par_pend <= (w_maj != w_exp_par);
      end
    end
  end

  // Registered result pulses and the output word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p_data     <= '0;
      r_data_valid <= 1'b0;
      r_par_err    <= 1'b0;
      r_stp_err    <= 1'b0;
    end else begin
      r_data_valid <= w_valid_nxt;
      r_par_err    <= w_par_err_nxt;
      r_stp_err    <= w_stp_err_nxt;
      if (w_valid_nxt) begin
        r_p_data <= r_shift;
      end
    end
  end

endmodule
